// File: rtl/shift_chain_pkg.sv
// ---------------------------------------------------------------------------
// shift_chain_pkg
//
// Shared definitions for the shift-chain readout controller and its
// deserialiser:
//   state_t            : controller states (IDLE / SHIFT / HOLD), 2-bit encoded
//   HEAD_FILL_DEFAULT  : value fed into the first cell's serial input; it
//                        matches the power-up value of the cells
//   cntWidth()         : width of the bit counter for a given chain length
// ---------------------------------------------------------------------------
package shift_chain_pkg;

  // Controller states. IDLE keeps the chain capturing, SHIFT clocks it out,
  // HOLD presents the finished word to the consumer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Serial fill bit for cell 0; equal to the cell power-up value so the
  // chain refills with a known pattern while it is being shifted out.
  localparam logic HEAD_FILL_DEFAULT = 1'b1;

  // Counter width: enough to hold CHAIN_LEN-1, but never narrower than one
  // bit so that a single-cell chain still has a legal counter.
  function automatic int cntWidth(input int chainLen);
    int w;
    w = $clog2(chainLen);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_chain_reader_deser.sv
// ---------------------------------------------------------------------------
// shift_chain_deser
//
// Serial-in / parallel-out collector for the chain tail.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low clear
//   i_shiftEn   : shift one serial bit in on this edge
//   i_serial    : serial input (the chain tail)
//   o_nextWord  : WIDTH-bit word formed by the bits already collected plus
//                 the bit currently on i_serial; on the last shift edge this
//                 is the complete word, so the owner can register it without
//                 spending an extra cycle
// ---------------------------------------------------------------------------
module shift_chain_deser
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shiftEn,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_nextWord
);

  generate
    if (WIDTH > 1) begin : g_multi
      // Only WIDTH-1 earlier samples need storage: the newest sample is
      // taken straight from i_serial when the word is assembled.
      logic [WIDTH-2:0] r_shreg;
      logic [WIDTH-1:0] w_nextWord;

      assign w_nextWord = {r_shreg, i_serial};
      assign o_nextWord = w_nextWord;

      // Earlier samples move towards the MSB, so the first bit out of the
      // chain ends up in bit WIDTH-1 once all WIDTH samples are in.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shreg <= '0;
        end else if (i_shiftEn) begin
          r_shreg <= w_nextWord[WIDTH-2:0];
        end
      end
    end else begin : g_single
      // A single-cell chain needs no storage: the word is the tail itself.
      logic w_unused;

      assign w_unused   = &{1'b0, clk, rst_n, i_shiftEn};
      assign o_nextWord = i_serial;
    end
  endgenerate

endmodule

// File: rtl/shift_chain_reader.sv
// ---------------------------------------------------------------------------
// shift_chain_reader
//
// Readout controller for a chain of single-bit shift cells. In IDLE the chain
// captures its parallel inputs every edge; a start request freezes that
// snapshot and the chain is clocked CHAIN_LEN times, collecting the tail into
// a parallel word that is then offered through a valid/ready handshake.
//
// Parameters:
//   CHAIN_LEN   : number of cells and width of the result word (1..256)
//   HEAD_FILL   : constant driven into the first cell's serial input
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : request one readout (acted on only in IDLE)
//   chain_shift : common shift select, 0 = capture, 1 = shift
//   chain_head  : serial input of cell 0
//   chain_tail  : registered output of the last cell
//   busy        : high while shifting or holding a word
//   rd_data     : captured word, bit k = cell k's snapshot value
//   rd_valid    : rd_data is valid
//   rd_ready    : consumer accepts rd_data
// ---------------------------------------------------------------------------
module shift_chain_reader
  import shift_chain_pkg::*;
#(
  parameter int   CHAIN_LEN = 32,
  parameter logic HEAD_FILL = HEAD_FILL_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 chain_shift,
  output logic                 chain_head,
  input  logic                 chain_tail,
  output logic                 busy,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready
);

  localparam int              CNT_W    = cntWidth(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_t                 r_state;
  logic                   r_chainShift;
  logic                   r_busy;
  logic                   r_rdValid;
  logic [CHAIN_LEN-1:0]   r_rdData;
  logic [CNT_W-1:0]       r_bitCnt;

  logic                   w_shiftEn;
  logic [CHAIN_LEN-1:0]   w_nextWord;

  // The tail is only looked at while shifting, so an undefined tail during
  // capture or hold can never reach the collected word.
  assign w_shiftEn = (r_state == ST_SHIFT);

  shift_chain_deser #(
    .WIDTH (CHAIN_LEN)
  ) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shiftEn  (w_shiftEn),
    .i_serial   (chain_tail),
    .o_nextWord (w_nextWord)
  );

  // Control FSM. chain_shift, busy and rd_valid are registered alongside the
  // state so that the chain select is glitch-free. The snapshot is the
  // capture at the start edge itself: chain_shift is still 0 on that edge and
  // only rises after it. The counter is not advanced on the exit edge, so it
  // never has to represent CHAIN_LEN and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_chainShift <= 1'b0;
      r_busy       <= 1'b0;
      r_rdValid    <= 1'b0;
      r_rdData     <= '0;
      r_bitCnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_SHIFT;
            r_bitCnt     <= '0;
            r_chainShift <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (r_bitCnt == LAST_CNT) begin
            r_rdData     <= w_nextWord;
            r_rdValid    <= 1'b1;
            r_chainShift <= 1'b0;
            r_state      <= ST_HOLD;
          end else begin
            r_bitCnt <= r_bitCnt + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          // rd_data is untouched here, so it stays stable until accepted.
          if (rd_ready) begin
            r_rdValid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_chainShift <= 1'b0;
          r_busy       <= 1'b0;
          r_rdValid    <= 1'b0;
        end
      endcase
    end
  end

  assign chain_shift = r_chainShift;
  assign chain_head  = HEAD_FILL;
  assign busy        = r_busy;
  assign rd_data     = r_rdData;
  assign rd_valid    = r_rdValid;

endmodule

// File: tb/tb_shift_chain_reader.sv
// ---------------------------------------------------------------------------
// tb_shift_chain_reader
//
// Drives an 8-cell and a 1-cell instance of shift_chain_reader, each wired to
// behavioural shift cells. Expected words are queued when a readout is
// requested; monitors pop and compare whenever a word appears on rd_valid.
// ---------------------------------------------------------------------------
module tb_shift_chain_reader;

  logic       clk = 1'b0;
  logic       rst_n;

  // 8-cell instance
  logic       start;
  logic       chainShift;
  logic       chainHead;
  logic       chainTail;
  logic       busy;
  logic [7:0] rdData;
  logic       rdValid;
  logic       rdReady;
  logic [7:0] pin;
  logic [7:0] cells = 8'hFF;

  // 1-cell instance
  logic       start1;
  logic       chainShift1;
  logic       chainHead1;
  logic       busy1;
  logic [0:0] rdData1;
  logic       rdValid1;
  logic       rdReady1;
  logic       pin1;
  logic       cell1 = 1'b1;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         wordsSeen  = 0;
  int         wordsSeen1 = 0;
  int         prevRise = 0;
  int         lastRise = 0;

  logic [7:0] expQ[$];
  logic       expQ1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  shift_chain_reader #(
    .CHAIN_LEN (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .chain_shift (chainShift),
    .chain_head  (chainHead),
    .chain_tail  (chainTail),
    .busy        (busy),
    .rd_data     (rdData),
    .rd_valid    (rdValid),
    .rd_ready    (rdReady)
  );

  shift_chain_reader #(
    .CHAIN_LEN (1)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .chain_shift (chainShift1),
    .chain_head  (chainHead1),
    .chain_tail  (cell1),
    .busy        (busy1),
    .rd_data     (rdData1),
    .rd_valid    (rdValid1),
    .rd_ready    (rdReady1)
  );

  // Behavioural cells: cell k+1 takes cell k when shifting, else parallel in.
  always @(posedge clk) begin
    if (chainShift) cells <= {cells[6:0], chainHead};
    else            cells <= pin;
  end
  assign chainTail = cells[7];

  always @(posedge clk) begin
    if (chainShift1) cell1 <= chainHead1;
    else             cell1 <= pin1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the 8-cell instance.
  logic       prevValid = 1'b0;
  logic [7:0] prevData  = 8'h00;
  always @(negedge clk) begin
    if (rdValid && !prevValid) begin
      wordsSeen++;
      prevRise = lastRise;
      lastRise = cyc;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWord", {24'h0, rdData}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("rdData", {24'h0, rdData}, {24'h0, expQ.pop_front()});
      end
    end else if (rdValid && prevValid) begin
      checkOutput("rdDataStable", {24'h0, rdData}, {24'h0, prevData});
    end
    prevValid = rdValid;
    prevData  = rdData;
  end

  // Scoreboard monitor for the 1-cell instance.
  logic prevValid1 = 1'b0;
  always @(negedge clk) begin
    if (rdValid1 && !prevValid1) begin
      wordsSeen1++;
      if (expQ1.size() == 0) begin
        checkOutput("unexpectedWord1", {31'h0, rdData1}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("rdData1", {31'h0, rdData1}, {31'h0, expQ1.pop_front()});
      end
    end
    prevValid1 = rdValid1;
  end

  // Called #1 after a rising edge. Holds pAfter on the parallel inputs from
  // the cycle after the start edge; returns #1 after the start edge.
  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] pAfter,
                               input bit expectWord);
    pin   = p;
    start = 1'b1;
    if (expectWord) expQ.push_back(p);
    @(posedge clk);
    #1;
    start = 1'b0;
    pin   = pAfter;
  endtask

  // Called #1 after the start edge. Counts edges until rd_valid is seen and
  // the number of sampled cycles with chain_shift high on the way.
  task automatic waitValid(output int lat, output int shifts);
    bit found;
    found  = 1'b0;
    lat    = 0;
    shifts = chainShift ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rdValid) begin
        found = 1'b1;
        break;
      end
      if (chainShift) shifts++;
    end
    if (!found) checkOutput("validTimeout", 32'h0, 32'h1);
  endtask

  initial begin
    int  lat;
    int  shifts;
    int  wordsBefore;
    bit  holdOk;

    rst_n    = 1'b0;
    start    = 1'b0;
    rdReady  = 1'b0;
    pin      = 8'h00;
    start1   = 1'b0;
    rdReady1 = 1'b1;
    pin1     = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetChainShift", {31'h0, chainShift}, 32'h0);
    checkOutput("resetBusy",       {31'h0, busy},       32'h0);
    checkOutput("resetValid",      {31'h0, rdValid},    32'h0);
    checkOutput("resetData",       {24'h0, rdData},     32'h0);
    checkOutput("chainHead",       {31'h0, chainHead},  32'h1);
    #4 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Basic readout with consumer always ready
    rdReady = 1'b1;
    applyStimulus(8'hA5, 8'hA5, 1'b1);
    waitValid(lat, shifts);
    checkOutput("basicLatency", lat, 8);
    checkOutput("basicShiftCycles", shifts, 8);
    checkOutput("basicShiftLowInHold", {31'h0, chainShift}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("basicValidDrop", {31'h0, rdValid}, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Snapshot exactness: inputs change right after the start edge
    applyStimulus(8'h3C, 8'hFF, 1'b1);
    waitValid(lat, shifts);
    checkOutput("snapLatency", lat, 8);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure
    rdReady = 1'b0;
    applyStimulus(8'hA5, 8'h00, 1'b1);
    waitValid(lat, shifts);
    holdOk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!(rdValid && rdData == 8'hA5 && busy && !chainShift)) holdOk = 1'b0;
    end
    checkOutput("holdStable", {31'h0, holdOk}, 32'h1);
    rdReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("holdReleaseValid", {31'h0, rdValid}, 32'h0);
    checkOutput("holdReleaseBusy",  {31'h0, busy},    32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Start pulses while busy are ignored
    rdReady     = 1'b0;
    wordsBefore = wordsSeen;
    applyStimulus(8'hC3, 8'h81, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitValid(lat, shifts);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    rdReady = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("ignoredStartWords", wordsSeen - wordsBefore, 1);
    checkOutput("ignoredStartIdle", {31'h0, busy}, 32'h0);

    // Continuous start: two words, 10 cycles apart
    wordsBefore = wordsSeen;
    pin   = 8'h01;
    expQ.push_back(8'h01);
    expQ.push_back(8'h02);
    start = 1'b1;
    @(posedge clk);
    #1;
    pin = 8'h02;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("contWords", wordsSeen - wordsBefore, 2);
    checkOutput("contSpacing", lastRise - prevRise, 10);

    // Reset in the middle of a shift
    applyStimulus(8'h77, 8'h77, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstChainShift", {31'h0, chainShift}, 32'h0);
    checkOutput("midRstBusy",       {31'h0, busy},       32'h0);
    checkOutput("midRstValid",      {31'h0, rdValid},    32'h0);
    checkOutput("midRstData",       {24'h0, rdData},     32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h5A, 8'h5A, 1'b1);
    waitValid(lat, shifts);
    checkOutput("postRstLatency", lat, 8);
    repeat (3) @(posedge clk);
    #1;

    // Single-cell chain
    pin1   = 1'b0;
    start1 = 1'b1;
    expQ1.push_back(1'b0);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    checkOutput("len1Shift", {31'h0, chainShift1}, 32'h1);
    checkOutput("len1NotYetValid", {31'h0, rdValid1}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("len1Valid", {31'h0, rdValid1}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    pin1   = 1'b1;
    start1 = 1'b1;
    expQ1.push_back(1'b1);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("len1ValidOne", {31'h0, rdValid1}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("len1Words", wordsSeen1, 2);

    // Every queued expectation must have been consumed
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    checkOutput("scoreboardEmpty1", expQ1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
